// File: rtl/dsyst_test_pkg.sv
// Shared definitions for the test-vector player.
//   state_e      : player FSM states
//   EXP_LSB      : bit offset of the expected response inside a memory word
//   stim_lsb()   : bit offset of the stimulus inside a memory word
//   NONE_IDX     : all-ones "no failing vector" marker (slice to width)
//   DEF_*        : default geometry and MISR polynomial
package dsyst_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_APPLY,
    S_COMPARE,
    S_DONE
  } state_e;

  localparam int unsigned DEF_IN_W   = 60;
  localparam int unsigned DEF_OUT_W  = 26;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam logic [25:0] DEF_POLY   = 26'h2000023;

  // Expected response occupies the low bits; stimulus sits directly above it.
  localparam int unsigned EXP_LSB = 0;

  function automatic int unsigned stim_lsb(input int unsigned out_w);
    return out_w;
  endfunction

  // Wide enough for any index width in use; users take the low bits.
  localparam logic [15:0] NONE_IDX = '1;

endpackage

// File: rtl/test_vector_player_if.sv
// Memory + CUT bus of the test-vector player.
//   mem_rd/mem_addr : read strobe and word address to the vector memory
//   mem_rdata       : memory word, valid one cycle after mem_rd
//   cut_in          : stimulus driven to the circuit under test
//   cut_out         : response from the circuit under test
// master = player side, slave = memory/CUT side.
interface test_vector_player_if #(
  parameter int unsigned IN_W   = 60,
  parameter int unsigned OUT_W  = 26,
  parameter int unsigned ADDR_W = 8
);
  logic                    mem_rd;
  logic [ADDR_W-1:0]       mem_addr;
  logic [IN_W+OUT_W-1:0]   mem_rdata;
  logic [IN_W-1:0]         cut_in;
  logic [OUT_W-1:0]        cut_out;

  modport master (
    output mem_rd, mem_addr, cut_in,
    input  mem_rdata, cut_out
  );

  modport slave (
    input  mem_rd, mem_addr, cut_in,
    output mem_rdata, cut_out
  );
endinterface

// File: rtl/test_vector_player_misr.sv
// response_misr: multiple-input signature register over CUT responses.
//   clk, rst_n : clock, synchronous active-low reset (clears signature)
//   clr        : synchronous clear at the start of a run
//   en         : fold din into the signature this cycle
//   din        : sampled CUT response
//   sig        : current signature
module response_misr
  import dsyst_test_pkg::*;
#(
  parameter int unsigned      OUT_W = DEF_OUT_W,
  parameter logic [OUT_W-1:0] POLY  = DEF_POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] sig
);

  logic [OUT_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr)
      sig_d = '0;
    else if (en)
      // Galois shift: feed back POLY when the MSB falls out, then fold in data.
      sig_d = ({sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? POLY : '0)) ^ din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/test_vector_player.sv
// test_vector_player: plays stored stimulus/expected pairs into a CUT.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : pulse to begin a run (IDLE only; wins over abort)
//   abort           : ends a run from any busy state, no done pulse
//   num_vectors     : vectors to play, clamped to 2^ADDR_W
//   vp              : memory read port + CUT stimulus/response
//   busy, done      : run in progress / one-cycle completion pulse
//   pass            : last completed run had zero mismatches
//   fail_count      : mismatching vectors (saturating)
//   first_fail_idx  : first mismatching vector, all-ones when none
//   signature       : MISR over every sampled response of the run
module test_vector_player
  import dsyst_test_pkg::*;
#(
  parameter int unsigned      IN_W       = DEF_IN_W,
  parameter int unsigned      OUT_W      = DEF_OUT_W,
  parameter int unsigned      ADDR_W     = DEF_ADDR_W,
  parameter int unsigned      SETTLE_CYC = 4,
  parameter logic [OUT_W-1:0] POLY       = DEF_POLY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W:0]      num_vectors,
  test_vector_player_if.master vp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W:0]      fail_count,
  output logic [ADDR_W:0]      first_fail_idx,
  output logic [OUT_W-1:0]     signature
);

  localparam int unsigned   CW     = ADDR_W + 1;
  localparam int unsigned   SL     = stim_lsb(OUT_W);
  localparam logic [CW-1:0] NONE   = NONE_IDX[CW-1:0];
  localparam logic [CW-1:0] MAX_N  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0]    SET_LD = 8'(SETTLE_CYC - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       n_q, n_d, idx_q, idx_d;
  logic [CW-1:0]       fail_q, fail_d, ffi_q, ffi_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [OUT_W-1:0]    exp_q, exp_d;
  logic [IN_W-1:0]     cut_in_q, cut_in_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                pass_q, pass_d;
  logic                misr_clr, misr_en;
  logic [CW-1:0]       n_clamp;

  assign n_clamp = (num_vectors > MAX_N) ? MAX_N : num_vectors;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    fail_d     = fail_q;
    ffi_d      = ffi_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    cut_in_d   = cut_in_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    pass_d     = pass_q;
    misr_clr   = 1'b0;
    misr_en    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d    = n_clamp;
          fail_d = '0;
          pass_d = 1'b0;
          if (n_clamp != '0) begin
            idx_d      = '0;
            ffi_d      = NONE;
            misr_clr   = 1'b1;
            mem_rd_d   = 1'b1;
            mem_addr_d = '0;
            state_d    = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: state_d = S_WAIT_MEM;
      S_WAIT_MEM: begin
        cut_in_d = vp.mem_rdata[SL +: IN_W];
        exp_d    = vp.mem_rdata[EXP_LSB +: OUT_W];
        cnt_d    = SET_LD;
        state_d  = S_APPLY;
      end
      S_APPLY: begin
        if (cnt_q == '0) state_d = S_COMPARE;
        else             cnt_d   = cnt_q - 8'd1;
      end
      S_COMPARE: begin
        misr_en = 1'b1;
        if (vp.cut_out != exp_q) begin
          if (fail_q != NONE) fail_d = fail_q + 1'b1;
          if (ffi_q == NONE)  ffi_d  = idx_q;
        end
        if (idx_q == n_q - 1'b1) begin
          state_d = S_DONE;
        end else begin
          idx_d      = idx_q + 1'b1;
          mem_rd_d   = 1'b1;
          mem_addr_d = idx_d[ADDR_W-1:0];
          state_d    = S_FETCH;
        end
      end
      S_DONE: begin
        pass_d  = (fail_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition out of a busy state.
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      mem_rd_d = 1'b0;
      pass_d   = pass_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      fail_q     <= '0;
      ffi_q      <= NONE;
      cnt_q      <= '0;
      exp_q      <= '0;
      cut_in_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      ffi_q      <= ffi_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      cut_in_q   <= cut_in_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      pass_q     <= pass_d;
    end
  end

  response_misr #(.OUT_W(OUT_W), .POLY(POLY)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   (vp.cut_out),
    .sig   (signature)
  );

  assign vp.mem_rd      = mem_rd_q;
  assign vp.mem_addr    = mem_addr_q;
  assign vp.cut_in      = cut_in_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_test_vector_player.sv
module tb_test_vector_player;
  localparam int IN_W = 60, OUT_W = 26, ADDR_W = 8, S = 4, PER = S + 3;
  localparam logic [25:0] POLY = 26'h2000023;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [8:0]  num_vectors = '0;
  logic        busy, done, pass;
  logic [8:0]  fail_count, first_fail_idx;
  logic [25:0] signature;
  int total = 0, bad = 0;

  // Vector image and CUT behaviour, indexed by vector number.
  logic [59:0] stim_t [256];
  logic [25:0] exp_t  [256];
  logic [25:0] resp_t [256];
  logic [8:0]  addr_q [$];

  always #5 clk = ~clk;

  test_vector_player_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) vp ();

  test_vector_player #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W),
                       .SETTLE_CYC(S), .POLY(POLY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_vectors(num_vectors), .vp(vp), .busy(busy), .done(done),
    .pass(pass), .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .signature(signature)
  );

  // Memory: one-cycle read latency. CUT: stimulus low byte names the vector.
  always @(posedge clk) if (vp.mem_rd) vp.mem_rdata <= {stim_t[vp.mem_addr], exp_t[vp.mem_addr]};
  always_comb vp.cut_out = resp_t[vp.cut_in[7:0]];
  always @(negedge clk) if (vp.mem_rd) addr_q.push_back({1'b0, vp.mem_addr});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int err_pct);
    logic [63:0] r;
    for (int i = 0; i < 256; i++) begin
      r = {$urandom(), $urandom()};
      stim_t[i] = {r[59:8], 8'(i)};
      resp_t[i] = 26'($urandom());
      exp_t[i]  = resp_t[i];
      if ($urandom_range(99) < err_pct)
        resp_t[i] = resp_t[i] ^ (26'd1 << $urandom_range(25));
    end
  endtask

  // Starts a run; optionally re-pulses start at cycle 'poke' while busy.
  task automatic run(input logic [8:0] nv, input int poke, output int lat);
    addr_q.delete();
    num_vectors = nv;
    start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk); #1;
      start = (c == poke);
      if (c == poke) num_vectors = 9'd9;
      if (done) begin lat = c; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_run(input string tag, input logic [8:0] nv, input int poke);
    int n, lat, fails, addr_bad;
    logic [8:0]  ffi;
    logic [25:0] sig;
    n = (nv > 9'd256) ? 256 : int'(nv);
    run(nv, poke, lat);
    fails = 0; ffi = '1; sig = '0;
    for (int i = 0; i < n; i++) begin
      if (resp_t[i] != exp_t[i]) begin
        fails++;
        if (ffi == 9'h1FF) ffi = 9'(i);
      end
      sig = ((sig << 1) ^ (sig[25] ? POLY : 26'd0)) ^ resp_t[i];
    end
    addr_bad = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != 9'(i)) addr_bad++;
    chk({tag, ".latency"}, lat, n * PER + 1);
    chk({tag, ".pass"}, pass, fails == 0);
    chk({tag, ".fail_count"}, fail_count, fails);
    chk({tag, ".addr_count"}, addr_q.size(), n);
    chk({tag, ".addr_seq"}, addr_bad, 0);
    if (n > 0) begin
      chk({tag, ".first_fail"}, first_fail_idx, ffi);
      chk({tag, ".signature"}, signature, sig);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".mem_rd"}, vp.mem_rd, 0);
    chk({tag, ".mem_addr"}, vp.mem_addr, 0);
    chk({tag, ".cut_in"}, vp.cut_in, 0);
    chk({tag, ".fail_count"}, fail_count, 0);
    chk({tag, ".first_fail"}, first_fail_idx, 9'h1FF);
    chk({tag, ".signature"}, signature, 0);
  endtask

  initial begin
    int seen;
    fill(0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean n=3 run, then one corrupted response bit in vector 1.
    fill(0);
    check_run("n3_clean", 9'd3, 0);
    chk("n3_clean.first_fail_const", first_fail_idx, 9'h1FF);
    resp_t[1] = resp_t[1] ^ 26'd1;
    check_run("n3_err1", 9'd3, 0);
    chk("n3_err1.first_fail_const", first_fail_idx, 9'd1);
    chk("n3_err1.fail_const", fail_count, 9'd1);

    // n=0: done on the next cycle, no memory traffic.
    check_run("n0", 9'd0, 0);
    chk("n0.pass_const", pass, 1);

    // Single vector with response 1 from a zero signature.
    exp_t[0] = 26'd1; resp_t[0] = 26'd1;
    check_run("n1_sig", 9'd1, 0);
    chk("n1_sig.const", signature, 26'h0000001);

    // Abort during APPLY of vector 2, then an immediate clean restart.
    fill(0);
    addr_q.delete();
    num_vectors = 9'd5;
    start = 1'b1;
    seen = 0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) seen++;
      abort = (c == 18);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done_seen", seen + int'(done), 0);
    chk("abort.pass", pass, 0);
    check_run("abort_rerun", 9'd5, 0);

    // Reset for one cycle mid-run: everything back to reset values, no done.
    fill(30);
    num_vectors = 9'd5;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset_vals("midreset");
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("midreset.no_done", seen, 0);

    // Start pulsed while busy must not disturb the run.
    check_run("start_busy", 9'd4, 5);

    // Random runs, then the clamp boundary (511 -> 256 vectors).
    for (int k = 0; k < 6; k++) begin
      fill(25);
      check_run($sformatf("rand%0d", k), 9'($urandom_range(1, 20)), 0);
    end
    fill(5);
    check_run("clamp", 9'h1FF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
